// File: rtl/line_buffer_out.sv
// Ping-pong scanline buffer: one bank is displayed (and cleared behind the beam) while the other is rendered.
// Two clk_pix enables from hc to rgb_out; renderer writes are never stalled, and the whole pipeline holds while clk_pix is 0.
module line_buffer_out #(
    parameter int              DW       = 16,
    parameter logic [DW-1:0]   BG_COLOR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_pix,
    input  logic [8:0]    hc,
    input  logic [8:0]    vc,
    input  logic          hbl,
    input  logic          vbl,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          wr_en,
    input  logic [8:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          render_start,
    output logic [8:0]    render_line,
    output logic [DW-1:0] rgb_out,
    output logic          hbl_out,
    output logic          vbl_out,
    output logic          hsync_out,
    output logic          vsync_out
);

    logic [DW-1:0] bank0 [256];
    logic [DW-1:0] bank1 [256];

    logic          sel;
    logic          hbl_d;
    logic          swap;

    logic          rd_vld;
    logic [7:0]    rd_addr;
    logic          rd_bank;
    logic [DW-1:0] rd_dat;
    logic          hbl_p;
    logic          vbl_p;
    logic          hsync_p;
    logic          vsync_p;

    logic          wr_ok;
    logic          clr_ok;

    assign swap   = clk_pix & hbl & ~hbl_d;
    assign wr_ok  = wr_en & ~wr_addr[8];
    // The clear follows the bank it was read from, so a swap in between cannot redirect it.
    assign clr_ok = clk_pix & rd_vld & ~reset;

    // Renderer write is issued after the clear so it wins any same-address collision.
    always_ff @(posedge clk) begin
        if (clr_ok) begin
            if (rd_bank) bank1[rd_addr] <= BG_COLOR;
            else         bank0[rd_addr] <= BG_COLOR;
        end
        if (wr_ok) begin
            if (sel) bank0[wr_addr[7:0]] <= wr_data;
            else     bank1[wr_addr[7:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel          <= 1'b0;
            hbl_d        <= 1'b0;
            render_start <= 1'b0;
            render_line  <= '0;
            rd_vld       <= 1'b0;
            rd_addr      <= '0;
            rd_bank      <= 1'b0;
            rd_dat       <= '0;
            hbl_p        <= 1'b0;
            vbl_p        <= 1'b0;
            hsync_p      <= 1'b0;
            vsync_p      <= 1'b0;
            rgb_out      <= '0;
            hbl_out      <= 1'b0;
            vbl_out      <= 1'b0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
        end else begin
            render_start <= swap;
            if (swap) begin
                sel         <= ~sel;
                render_line <= vc + 9'd1;
            end
            if (clk_pix) begin
                hbl_d   <= hbl;
                rd_vld  <= ~hc[8];
                rd_addr <= hc[7:0];
                rd_bank <= sel;
                if (!hc[8]) begin
                    rd_dat <= sel ? bank1[hc[7:0]] : bank0[hc[7:0]];
                end
                hbl_p     <= hbl;
                vbl_p     <= vbl;
                hsync_p   <= hsync;
                vsync_p   <= vsync;
                hbl_out   <= hbl_p;
                vbl_out   <= vbl_p;
                hsync_out <= hsync_p;
                vsync_out <= vsync_p;
                // Positions past the buffer width show background without touching memory.
                if (hbl_p || vbl_p) rgb_out <= '0;
                else if (rd_vld)    rgb_out <= rd_dat;
                else                rgb_out <= BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_out.sv
// Directed line-by-line stimulus; a bank model predicts each pixel and a scoreboard queue aligns it with rgb_out.
module tb_line_buffer_out;

    localparam int          DW = 16;
    localparam logic [15:0] BG = 16'h0A5A;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_pix;
    logic [8:0]    hc, vc;
    logic          hbl, vbl, hsync, vsync;
    logic          wr_en;
    logic [8:0]    wr_addr;
    logic [15:0]   wr_data;
    logic          render_start;
    logic [8:0]    render_line;
    logic [15:0]   rgb_out;
    logic          hbl_out, vbl_out, hsync_out, vsync_out;

    line_buffer_out #(.DW(DW), .BG_COLOR(BG)) dut (
        .clk(clk), .reset(reset), .clk_pix(clk_pix),
        .hc(hc), .vc(vc), .hbl(hbl), .vbl(vbl), .hsync(hsync), .vsync(vsync),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .render_start(render_start), .render_line(render_line),
        .rgb_out(rgb_out), .hbl_out(hbl_out), .vbl_out(vbl_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rgb;
        bit          chk;
        logic        hb, vb, hs, vs;
    } exp_t;

    typedef struct {
        logic [8:0]  a;
        logic [15:0] d;
    } wr_t;

    exp_t        sb[$];
    wr_t         wq[$];
    logic [15:0] mmem [2][256];
    bit          mknown [2][256];
    bit          msel, mhbl_d, pend, pb;
    logic [7:0]  pa;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [8:0] a, input logic [15:0] d);
        if (!a[8]) begin
            mmem[!msel][a[7:0]]   = d;
            mknown[!msel][a[7:0]] = 1'b1;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rgb"}, rgb_out, 0);
        chk({tag, "_hbl"}, hbl_out, 0);
        chk({tag, "_vbl"}, vbl_out, 0);
        chk({tag, "_hs"}, hsync_out, 0);
        chk({tag, "_vs"}, vsync_out, 0);
        chk({tag, "_rs"}, render_start, 0);
        chk({tag, "_rl"}, render_line, 0);
    endtask

    task automatic pixel(input logic [8:0] h, input logic [8:0] v, input logic b_h, input logic b_v,
                         input logic s_h, input logic s_v, input bit cw,
                         input logic [8:0] ca, input logic [15:0] cd);
        exp_t        e;
        wr_t         w;
        logic [15:0] val;
        logic [8:0]  nl;
        bit          kn, sw;
        clk_pix = 1'b1; hc = h; vc = v; hbl = b_h; vbl = b_v; hsync = s_h; vsync = s_v;
        wr_en = cw; wr_addr = ca; wr_data = cd;
        val = 'x; kn = 1'b0;
        if (!h[8]) begin
            val = mmem[msel][h[7:0]];
            kn  = mknown[msel][h[7:0]];
        end
        if (pend) begin
            mmem[pb][pa]   = BG;
            mknown[pb][pa] = 1'b1;
        end
        pend = 1'b0;
        if (cw) model_write(ca, cd);
        if (!h[8]) begin
            pend = 1'b1; pb = msel; pa = h[7:0];
        end
        sw = b_h && !mhbl_d;
        mhbl_d = b_h;
        e.hb = b_h; e.vb = b_v; e.hs = s_h; e.vs = s_v;
        if (b_h || b_v) begin
            e.rgb = '0; e.chk = 1'b1;
        end else if (h[8]) begin
            e.rgb = BG; e.chk = 1'b1;
        end else begin
            e.rgb = val; e.chk = kn;
        end
        sb.push_back(e);
        tick();
        if (sw) msel = !msel;
        chk("render_start_en", render_start, sw);
        if (sw) begin
            nl = v + 9'd1;
            chk("render_line", render_line, nl);
        end
        if (sb.size() > 1) begin
            e = sb.pop_front();
            chk("hbl_out", hbl_out, e.hb);
            chk("vbl_out", vbl_out, e.vb);
            chk("hsync_out", hsync_out, e.hs);
            chk("vsync_out", vsync_out, e.vs);
            if (e.chk) chk("rgb_out", rgb_out, e.rgb);
        end
        clk_pix = 1'b0; wr_en = 1'b0;
        if (wq.size() > 0) begin
            w = wq.pop_front();
            wr_en = 1'b1; wr_addr = w.a; wr_data = w.d;
            model_write(w.a, w.d);
        end
        tick();
        chk("render_start_idle", render_start, 0);
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        clk_pix = 1'b0; wr_en = 1'b0; reset = 1'b1;
        tick();
        check_zero_outputs("midline_reset");
        reset = 1'b0;
        pend = 1'b0; msel = 1'b0; mhbl_d = 1'b0;
        sb.delete();
        repeat (3) begin
            tick();
            chk("post_reset_rs", render_start, 0);
        end
    endtask

    task automatic line(input logic [8:0] v, input logic vb, input int extra, input int rst_at,
                        input bit cw, input logic [8:0] ca, input logic [15:0] cd);
        logic [8:0] h;
        for (int x = 0; x < 256 + extra; x++) begin
            h = x[8:0];
            pixel(h, v, 1'b0, vb, 1'b0, vb, 1'b0, 9'd0, 16'd0);
            if (x == rst_at) do_reset();
        end
        for (int i = 0; i < 8; i++) begin
            h = 9'(256 + extra + i);
            if (cw && i == 0) wq.push_back('{9'h100, 16'hDEAD});
            pixel(h, v, 1'b1, vb, (i >= 2 && i < 6), vb, cw && (i == 0), ca, cd);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++) begin
                mmem[b][a] = '0; mknown[b][a] = 1'b0;
            end
        msel = 1'b0; mhbl_d = 1'b0; pend = 1'b0; pb = 1'b0; pa = '0;
        reset = 1'b1; clk_pix = 1'b0; hc = '0; vc = '0;
        hbl = 1'b0; vbl = 1'b0; hsync = 1'b0; vsync = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) tick();
        check_zero_outputs("reset");
        reset = 1'b0;

        wq.push_back('{9'd10, 16'h1234});
        wq.push_back('{9'd20, 16'h00FF});
        line(9'd98, 1'b0, 0, -1, 1'b0, 9'd0, 16'd0);
        wq.push_back('{9'd5, 16'h1111});
        wq.push_back('{9'd255, 16'h2222});
        wq.push_back('{9'd0, 16'h3333});
        line(9'd99, 1'b0, 0, -1, 1'b0, 9'd0, 16'd0);
        line(9'd100, 1'b0, 0, -1, 1'b0, 9'd0, 16'd0);
        line(9'd101, 1'b0, 0, -1, 1'b0, 9'd0, 16'd0);
        line(9'd102, 1'b0, 0, -1, 1'b1, 9'd30, 16'hBEEF);
        line(9'd103, 1'b0, 4, -1, 1'b0, 9'd0, 16'd0);
        wq.push_back('{9'd40, 16'h7777});
        line(9'd104, 1'b1, 0, -1, 1'b0, 9'd0, 16'd0);
        line(9'd105, 1'b1, 0, -1, 1'b0, 9'd0, 16'd0);
        line(9'd511, 1'b0, 0, -1, 1'b0, 9'd0, 16'd0);
        wq.push_back('{9'd60, 16'h4242});
        line(9'd106, 1'b0, 0, 50, 1'b0, 9'd0, 16'd0);
        line(9'd107, 1'b0, 0, -1, 1'b0, 9'd0, 16'd0);
        line(9'd108, 1'b0, 0, -1, 1'b0, 9'd0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_buffer_out.md
LINE_BUFFER_OUT -- requirements
Module: line_buffer_out

Interface
REQ-001 Parameter: DW, 16, pixel word width in bits.
REQ-002 Parameter: BG_COLOR, 0, DW-bit value written back to each pixel after it is read.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clk_pix  input  1  pixel clock enable; all video-side state advances only when it is 1.
REQ-006 hc  input  9  horizontal counter from the timing generator; visible range 0..255.
REQ-007 vc  input  9  vertical counter from the timing generator.
REQ-008 hbl, vbl, hsync, vsync  input  1 each  blanking and sync signals from the timing generator.
REQ-009 wr_en  input  1  renderer write strobe; sampled on any clk, independent of clk_pix.
REQ-010 wr_addr  input  9  renderer write x position.
REQ-011 wr_data  input  DW  renderer pixel word.
REQ-012 render_start  output  1  one-clk pulse requesting the renderer to draw the next line.
REQ-013 render_line  output  9  line number to render; valid from render_start until the next render_start.
REQ-014 rgb_out  output  DW  pixel word to the video output.
REQ-015 hbl_out, vbl_out, hsync_out, vsync_out  output  1 each  blanking and sync signals, aligned with rgb_out.

Function
REQ-016 The block SHALL hold two banks of 256 x DW; bank sel is the read bank and bank ~sel is the write bank.
REQ-017 Swap event: the block SHALL register hbl on every clk_pix (hbl_d) and detect a swap when clk_pix=1, hbl=1 and hbl_d=0.
REQ-018 On a swap, the block SHALL toggle sel, pulse render_start for exactly one clk, and load render_line with vc+1 modulo 512.
REQ-019 Write: when wr_en=1 and wr_addr[8]=0, wr_data SHALL be written to address wr_addr[7:0] of the write bank, using the sel value held before any same-clk swap.
REQ-020 Writes with wr_addr[8]=1 SHALL be ignored.
REQ-021 Read: on each clk_pix with hc[8]=0, the block SHALL read address hc[7:0] of bank sel.
REQ-022 Clear-after-read: on the clk_pix following each read, the block SHALL write BG_COLOR to the same address of the same bank, even if a swap occurred in between.
REQ-023 Because of clear-after-read, the renderer writes opaque pixels only; unwritten pixels read back as BG_COLOR.
REQ-024 Renderer writes SHALL never be blocked by clear-after-read; the two SHALL target different banks.
REQ-025 The pipeline latency SHALL be exactly 2 clk_pix enables from hc to rgb_out.
REQ-026 hbl, vbl, hsync and vsync SHALL pass through a matching 2-stage clk_pix-enabled delay to the *_out outputs.
REQ-027 rgb_out SHALL be 0 whenever the delayed hbl or delayed vbl is 1; otherwise it SHALL be the pixel read.
REQ-028 When clk_pix=0, all outputs and pipeline state SHALL hold.
REQ-029 hc >= 256 while hbl=0 SHALL output BG_COLOR; no memory access SHALL occur at that position.

Reset
REQ-030 On reset=1, the block SHALL clear sel, hbl_d, render_start and render_line to 0.
REQ-031 On reset=1, the block SHALL clear rgb_out, all *_out signals and all pipeline stages to 0.
REQ-032 Reset SHALL cancel any pending clear-after-read write.
REQ-033 Bank contents are not reset; output is defined only from the second swap after reset onward.
REQ-034 Reset asserted mid-line SHALL take effect on the next clk, regardless of clk_pix.

Verification
REQ-035 Swap: hbl rises with vc=100 -> one-clk render_start=1, render_line=101, sel toggles.
REQ-036 Write/read: write 0x1234 to x=10 during line N; on line N+1, hc=10 -> rgb_out=0x1234 two clk_pix later, with hbl_out low.
REQ-037 Clear-after-read: no writes for one full line after a displayed line -> every visible pixel on the second display of that bank equals BG_COLOR.
REQ-038 Blanking: hbl=1 or vbl=1 with nonzero buffer data -> rgb_out=0; *_out signals equal the inputs delayed by exactly 2 clk_pix.
REQ-039 Boundary: a write coincident with the swap clk, then a write with wr_addr=0x100 -> the first lands in the pre-swap write bank and the second is discarded.
REQ-040 Reset mid-line with clk_pix=0 -> all outputs are 0 on the next clk and render_start does not pulse until the next hbl rise.
